// File: rtl/fetch_queue.sv
// fetch_queue: in-order buffer of {pc, instr} pairs from fetch to decode.
// It uses a circular buffer with valid/ready handshakes on both sides.
// A flush (redirect) discards everything. There is no enq->deq bypass.
module fetch_queue #(
  parameter int              DEPTH     = 4,
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       n_rst,      // active-high despite the name
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [XLEN-1:0]            enq_instr,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic            enq_fire;
  logic            deq_fire;

  // Handshake qualifiers depend only on registered count, flush and reset.
  // This keeps deq_ready from reaching enq_ready combinationally.
  always_comb begin
    enq_ready = !n_rst && !flush && (count != CW'(DEPTH));
    deq_valid = !n_rst && !flush && (count != '0);
    enq_fire  = enq_valid && enq_ready;
    deq_fire  = deq_valid && deq_ready;
  end

  // Head presentation: show the stored entry when occupied, else pc=0 and a NOP.
  // NOTE: every output of a combinational block gets a default first, so that no path leaves it unassigned and infers a latch.
  always_comb begin
    deq_pc    = '0;
    deq_instr = NOP_INSTR;
    if (count != '0) begin
      deq_pc    = pc_mem[rd_ptr];
      deq_instr = instr_mem[rd_ptr];
    end
  end

  // Pointer and occupancy state. Flush wins over both handshakes.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. It is written on an accepted enqueue only.
  // NOTE: the storage array has no reset; count gates visibility, so stale contents are never observed and the array can map to plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[wr_ptr]    <= enq_pc;
      instr_mem[wr_ptr] <= enq_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            flush;
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_instr;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_instr;
  logic [2:0]      count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  // Present one enqueue for a single edge, with decode stalled.
  task automatic push(input logic [31:0] pc);
    enq_valid = 1'b1;
    enq_pc    = pc;
    enq_instr = instr_of(pc);
    deq_ready = 1'b0;
    step();
    enq_valid = 1'b0;
  endtask

  initial begin
    n_rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_pc = '0; enq_instr = '0;

    // 1: reset state, then release between edges
    #1;
    check("rst_count",     32'(count),     32'd0);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_deq_instr", deq_instr,      NOP);
    check("rst_deq_pc",    deq_pc,         32'd0);
    check("rst_enq_ready", 32'(enq_ready), 32'd0);
    step(); step();
    n_rst = 1'b0;
    #1;
    check("rel_enq_ready", 32'(enq_ready), 32'd1);

    // 2: fill to full, full blocks enq even with deq_ready, then drain in order
    for (int i = 0; i < 4; i++) push(32'(4 * i));
    check("full_count",     32'(count),     32'd4);
    check("full_enq_ready", 32'(enq_ready), 32'd0);
    enq_valid = 1'b1; enq_pc = 32'h50; enq_instr = instr_of(32'h50); deq_ready = 1'b1;
    #1;
    check("full_rdy_deq",   32'(enq_ready), 32'd0);
    enq_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(deq_valid), 32'd1);
      check("drain_pc",    deq_pc,         32'(4 * i));
      check("drain_instr", deq_instr,      instr_of(32'(4 * i)));
      step();
    end
    deq_ready = 1'b0;
    check("empty_valid", 32'(deq_valid), 32'd0);
    check("empty_count", 32'(count),     32'd0);
    check("empty_instr", deq_instr,      NOP);
    check("empty_pc",    deq_pc,         32'd0);

    // 3: steady state at count=2 with simultaneous enq/deq, pointers wrap
    push(32'h200);
    push(32'h204);
    for (int i = 0; i < 10; i++) begin
      enq_valid = 1'b1; deq_ready = 1'b1;
      enq_pc = 32'h208 + 32'(4 * i); enq_instr = instr_of(enq_pc);
      #1;
      check("ss_count", 32'(count), 32'd2);
      check("ss_pc",    deq_pc,     32'h200 + 32'(4 * i));
      step();
    end
    enq_valid = 1'b0; deq_ready = 1'b0;
    check("ss_end_count", 32'(count), 32'd2);
    check("ss_end_pc",    deq_pc,     32'h228);

    // 4: count=3, flush suppresses both handshakes and empties next edge
    push(32'h300);
    check("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; enq_valid = 1'b1; deq_ready = 1'b1;
    enq_pc = 32'h3F0; enq_instr = instr_of(32'h3F0);
    #1;
    check("flush_enq_ready", 32'(enq_ready), 32'd0);
    check("flush_deq_valid", 32'(deq_valid), 32'd0);
    step();
    flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    check("post_flush_count", 32'(count),     32'd0);
    check("post_flush_valid", 32'(deq_valid), 32'd0);
    enq_valid = 1'b1; enq_pc = 32'h100; enq_instr = instr_of(32'h100);
    #1;
    check("nobypass_100", 32'(deq_valid), 32'd0);
    step();
    enq_valid = 1'b0;
    check("after_flush_valid", 32'(deq_valid), 32'd1);
    check("after_flush_pc",    deq_pc,         32'h100);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    check("drain_100_count", 32'(count), 32'd0);

    // 5: one-cycle latency from empty
    enq_valid = 1'b1; enq_pc = 32'h20; enq_instr = instr_of(32'h20);
    #1;
    check("lat_before_valid", 32'(deq_valid), 32'd0);
    step();
    enq_valid = 1'b0;
    check("lat_after_valid", 32'(deq_valid), 32'd1);
    check("lat_after_pc",    deq_pc,         32'h20);
    check("lat_after_instr", deq_instr,      instr_of(32'h20));

    // 6: async reset pulse between edges at count=2
    push(32'h400);
    check("pre_rst_count", 32'(count), 32'd2);
    #2 n_rst = 1'b1;
    #1;
    check("async_count",     32'(count),     32'd0);
    check("async_deq_valid", 32'(deq_valid), 32'd0);
    check("async_enq_ready", 32'(enq_ready), 32'd0);
    #1 n_rst = 1'b0;
    enq_valid = 1'b1; enq_pc = 32'h500; enq_instr = instr_of(32'h500);
    #1;
    check("post_rst_enq_ready", 32'(enq_ready), 32'd1);
    step();
    enq_valid = 1'b0;
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_pc",    deq_pc,     32'h500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
